// File: rtl/uart_tx_if.sv
// CPU-facing bus of the UART transmitter: store strobe, store data, status and line.
interface uart_tx_if;
    logic        uart_write;
    logic [31:0] data_in;
    logic        uart_busy;
    logic        tx_active;
    logic        tx;

    // CPU / address-decoder side
    modport master (
        output uart_write,
        output data_in,
        input  uart_busy,
        input  tx_active,
        input  tx
    );

    // Transmitter side
    modport slave (
        input  uart_write,
        input  data_in,
        output uart_busy,
        output tx_active,
        output tx
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with a one-entry holding register in front of the shifter.
module uart_tx #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned STOP_BITS = 1
) (
    input logic     clk,
    input logic     rst,
    uart_tx_if.slave bus
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shifter_q, shifter_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic             tx_q, tx_d;

    logic bit_end;
    logic last_data;
    logic last_stop;

    // Upper store bits carry no meaning for a byte-wide transmitter.
    logic unused_data;
    assign unused_data = ^bus.data_in[31:8];

    assign bit_end   = (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign last_data = (bit_idx_q == 3'd7);
    // In STOP, bit_idx counts stop bits instead of data bits.
    assign last_stop = (bit_idx_q == 3'(STOP_BITS - 1));

    // Next-state: holding-register fill, then frame sequencing and drain.
    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q;
        bit_idx_d    = bit_idx_q;
        shifter_d    = shifter_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        tx_d         = tx_q;

        // Drain only happens while hold_valid_q=1, so it never collides with a fill.
        if (bus.uart_write && !hold_valid_q) begin
            hold_d       = bus.data_in[7:0];
            hold_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d       = 1'b1;
                baud_cnt_d = '0;
                if (hold_valid_q) begin
                    shifter_d    = hold_q;
                    hold_valid_d = 1'b0;
                    tx_d         = 1'b0;
                    state_d      = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    tx_d       = shifter_q[0];
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (last_data) begin
                        bit_idx_d = 3'd0;
                        tx_d      = 1'b1;
                        state_d   = STOP;
                    end else begin
                        // Shift right so the next bit is always at shifter[1] -> shifter[0].
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shifter_q[1];
                        shifter_d = {1'b0, shifter_q[7:1]};
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (last_stop) begin
                        bit_idx_d = 3'd0;
                        if (hold_valid_q) begin
                            // Back-to-back frame: no idle gap after the stop bit(s).
                            shifter_d    = hold_q;
                            hold_valid_d = 1'b0;
                            tx_d         = 1'b0;
                            state_d      = START;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any frame and queued byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            baud_cnt_q   <= '0;
            bit_idx_q    <= 3'd0;
            shifter_q    <= 8'd0;
            hold_q       <= 8'd0;
            hold_valid_q <= 1'b0;
            tx_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shifter_q    <= shifter_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            tx_q         <= tx_d;
        end
    end

    assign bus.uart_busy = hold_valid_q;
    assign bus.tx_active = (state_q != IDLE);
    assign bus.tx        = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: 1-stop and 2-stop instances, frame-position reference model,
// per-cycle comparison plus literal frame checks.
module tb_uart_tx;

    localparam int C = 10;  // clocks per bit at 1 MHz / 100 kbaud

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_if busa ();
    uart_tx_if busb ();

    uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .STOP_BITS(1)) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(busa)
    );

    uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .STOP_BITS(2)) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(busb)
    );

    int checks   = 0;
    int failures = 0;

    int stopb[2] = '{1, 2};

    // Reference model: which frame is on the line and how far into it we are.
    bit         m_act[2];
    int         m_pos[2];
    logic [7:0] m_cur[2];
    logic [7:0] m_hold[2];
    bit         m_hv[2];
    bit         chk_en = 1'b0;

    int   cyc = 0;
    logic r_tx[2][4096];
    logic r_act[2][4096];
    logic r_busy[2][4096];
    logic r_mtx[2][4096];
    logic r_mact[2][4096];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_tx(input int d);
        int p;
        if (!m_act[d]) return 1'b1;
        p = m_pos[d];
        if (p < C) return 1'b0;
        if (p < 9 * C) return m_cur[d][(p - C) / C];
        return 1'b1;
    endfunction

    function automatic logic dut_sig(input int d, input int which);
        case (which)
            0:       return d ? busb.tx : busa.tx;
            1:       return d ? busb.uart_busy : busa.uart_busy;
            default: return d ? busb.tx_active : busa.tx_active;
        endcase
    endfunction

    // Model update on every active edge from the inputs sampled at that edge.
    initial begin
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 0; m_pos[d] = 0; m_hv[d] = 0; m_cur[d] = 0; m_hold[d] = 0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                logic        wr;
                logic [31:0] dat;
                bit          old;
                wr  = d ? busb.uart_write : busa.uart_write;
                dat = d ? busb.data_in : busa.data_in;
                if (rst) begin
                    m_act[d] = 0; m_pos[d] = 0; m_hv[d] = 0;
                end else begin
                    old = m_hv[d];
                    if (m_act[d] && m_pos[d] < (9 + stopb[d]) * C - 1) begin
                        m_pos[d]++;
                    end else if (old) begin
                        m_act[d] = 1; m_pos[d] = 0; m_cur[d] = m_hold[d]; m_hv[d] = 0;
                    end else begin
                        m_act[d] = 0;
                    end
                    if (wr && !old) begin
                        m_hold[d] = dat[7:0];
                        m_hv[d]   = 1;
                    end
                end
            end
        end
    end

    // Record DUT and model on the falling edge and compare every cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                string nm;
                int    ix;
                nm = d ? "b" : "a";
                ix = cyc % 4096;
                r_tx[d][ix]   = dut_sig(d, 0);
                r_busy[d][ix] = dut_sig(d, 1);
                r_act[d][ix]  = dut_sig(d, 2);
                r_mtx[d][ix]  = model_tx(d);
                r_mact[d][ix] = m_act[d];
                if (chk_en) begin
                    check({"tx_", nm}, 32'(dut_sig(d, 0)), 32'(model_tx(d)));
                    check({"busy_", nm}, 32'(dut_sig(d, 1)), 32'(m_hv[d]));
                    check({"active_", nm}, 32'(dut_sig(d, 2)), 32'(m_act[d]));
                end
            end
            cyc++;
        end
    end

    function automatic logic rec_tx(input int d, input int ix, input int m);
        return m ? r_mtx[d][ix % 4096] : r_tx[d][ix % 4096];
    endfunction

    function automatic int count_act(input int d, input int from, input int n, input int m);
        int c = 0;
        for (int i = 0; i < n; i++)
            c += int'(m ? r_mact[d][(from + i) % 4096] : r_act[d][(from + i) % 4096]);
        return c;
    endfunction

    function automatic int count_low(input int d, input int from, input int n, input int m);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(!rec_tx(d, from + i, m));
        return c;
    endfunction

    function automatic logic [7:0] decode(input int d, input int start, input int m);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = rec_tx(d, start + C + k * C + C / 2, m);
        return b;
    endfunction

    // Literal frame checks applied to both the DUT record and the model record.
    task automatic frame_chk(input string nm, input int d, input int start, input logic [7:0] v);
        for (int m = 0; m < 2; m++) begin
            check({nm, m ? "_model_byte" : "_dut_byte"}, 32'(decode(d, start, m)), 32'(v));
            check({nm, m ? "_model_start" : "_dut_start"}, 32'(rec_tx(d, start, m)), 32'd0);
            check({nm, m ? "_model_stop" : "_dut_stop"},
                  32'(count_low(d, start + 9 * C, stopb[d] * C, m)), 32'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] v);
        busa.uart_write = 1'b1; busa.data_in = v;
        busb.uart_write = 1'b1; busb.data_in = v;
        step();
        busa.uart_write = 1'b0; busa.data_in = $urandom;
        busb.uart_write = 1'b0; busb.data_in = $urandom;
    endtask

    initial begin
        int t0, t1, t2;
        rst = 1'b1;
        busa.uart_write = 1'b0; busa.data_in = '0;
        busb.uart_write = 1'b0; busb.data_in = '0;

        // 1: reset, then a silent line
        repeat (3) step();
        chk_en = 1'b1;
        rst    = 1'b0;
        t0     = cyc;
        repeat (200) step();
        for (int d = 0; d < 2; d++) begin
            check("rst_tx", 32'(r_tx[d][t0 % 4096]), 32'd1);
            check("rst_busy", 32'(r_busy[d][t0 % 4096]), 32'd0);
            check("rst_active", 32'(r_act[d][t0 % 4096]), 32'd0);
            check("idle_low_cnt", 32'(count_low(d, t0, 200, 0)), 32'd0);
        end

        // 2: single byte 0xA5
        wr(32'h0000_00A5);
        t0 = cyc;
        repeat (125) step();
        frame_chk("a5_a", 0, t0 + 1, 8'hA5);
        frame_chk("a5_b", 1, t0 + 1, 8'hA5);
        for (int m = 0; m < 2; m++) begin
            check("a5_active_a", 32'(count_act(0, t0, 125, m)), 32'd100);
            check("a5_active_b", 32'(count_act(1, t0, 125, m)), 32'd110);
            check("a5_bit0_edge", 32'(rec_tx(0, t0 + C + 1, m)), 32'd1);
        end
        check("a5_busy_cnt",
              32'(int'(r_busy[0][t0 % 4096]) + int'(r_busy[0][(t0 + 1) % 4096])), 32'd1);
        check("a5_no_early_low", 32'(r_tx[0][t0 % 4096]), 32'd1);

        // 3: second byte queued mid-frame goes out back-to-back
        wr(32'h41);
        t0 = cyc;
        repeat (4) step();
        wr(32'h42);
        repeat (240) step();
        frame_chk("bb1_a", 0, t0 + 1, 8'h41);
        frame_chk("bb2_a", 0, t0 + 101, 8'h42);
        frame_chk("bb2_b", 1, t0 + 111, 8'h42);
        check("bb_active_a", 32'(count_act(0, t0, 240, 0)), 32'd200);
        check("bb_active_b", 32'(count_act(1, t0, 240, 0)), 32'd220);
        check("bb_end_a", 32'(r_act[0][(t0 + 201) % 4096]), 32'd0);

        // 4: third write while busy is dropped
        wr(32'h41);
        t0 = cyc;
        step(); step();
        wr(32'h42);
        wr(32'h55);
        repeat (260) step();
        frame_chk("drop1_a", 0, t0 + 1, 8'h41);
        frame_chk("drop2_a", 0, t0 + 101, 8'h42);
        check("drop_active_a", 32'(count_act(0, t0, 260, 0)), 32'd200);
        check("drop_active_b", 32'(count_act(1, t0, 260, 0)), 32'd220);

        // 5: reset during data bit 3, then a clean frame
        wr(32'hC3);
        t0 = cyc;
        repeat (44) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        t1 = cyc;
        step();
        for (int d = 0; d < 2; d++) begin
            check("mid_bit3_tx", 32'(r_tx[d][(t1 - 1) % 4096]), 32'd0);
            check("mid_rst_tx", 32'(r_tx[d][t1 % 4096]), 32'd1);
            check("mid_rst_busy", 32'(r_busy[d][t1 % 4096]), 32'd0);
            check("mid_rst_active", 32'(r_act[d][t1 % 4096]), 32'd0);
        end
        wr(32'hFF);
        t2 = cyc;
        repeat (125) step();
        frame_chk("ff_a", 0, t2 + 1, 8'hFF);
        check("ff_active_a", 32'(count_act(0, t2, 125, 0)), 32'd100);

        // 6: 0x00 on the two-stop-bit instance
        wr(32'h00);
        t0 = cyc;
        repeat (125) step();
        frame_chk("zero_b", 1, t0 + 1, 8'h00);
        for (int m = 0; m < 2; m++) begin
            check("zero_low_b", 32'(count_low(1, t0, 125, m)), 32'd90);
            check("zero_active_b", 32'(count_act(1, t0, 125, m)), 32'd110);
            check("zero_active_a", 32'(count_act(0, t0, 125, m)), 32'd100);
        end

        // Random traffic against the per-cycle model comparison
        for (int i = 0; i < 4000; i++) begin
            busa.uart_write = ($urandom_range(0, 7) == 0);
            busa.data_in    = $urandom;
            busb.uart_write = ($urandom_range(0, 7) == 0);
            busb.data_in    = $urandom;
            rst             = ($urandom_range(0, 1999) == 0);
            step();
        end
        busa.uart_write = 1'b0;
        busb.uart_write = 1'b0;
        rst             = 1'b0;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
